// File: rtl/halfword_unpacker.sv
// Splits each accepted N-bit word into its high and low halves on an N/2-bit bus, high half first.
// Define HALFWORD_UNPACKER_PARITY_EN to add out_par, the even parity of out_data.
module halfword_unpacker #(
   parameter int N     = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [N-1:0]     in_data,
   input  logic             in_en_h,
   input  logic             in_en_l,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [N/2-1:0]   out_data,
   output logic             out_is_hi,
   output logic             out_last,
   output logic             out_valid,
`ifdef HALFWORD_UNPACKER_PARITY_EN
   output logic             out_par,
`endif
   input  logic             out_ready,
   output logic [CNT_W-1:0] sent_cnt
);
   localparam int H = N / 2;

   typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} state_t;

   state_t             state_q, state_d;
   logic [N-1:0]       word_q;
   logic               en_l_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               xfer, accept;

   // Outputs come only from registered state, so in_* never reaches out_*.
   assign out_valid = (state_q != IDLE);
   assign out_is_hi = (state_q == SEND_HI);
   assign out_last  = (state_q == SEND_LO) | ((state_q == SEND_HI) & ~en_l_q);
   assign sent_cnt  = cnt_q;

   always_comb begin
      out_data = '0;
      case (state_q)
         SEND_HI: out_data = word_q[N-1:H];
         SEND_LO: out_data = word_q[H-1:0];
         default: out_data = '0;
      endcase
   end

   // Finishing the last half frees the slot in the same cycle: zero-bubble back-to-back words.
   assign xfer     = out_valid & out_ready;
   assign in_ready = (state_q == IDLE) | (xfer & out_last);
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      if (accept) begin
         if (in_en_h)      state_d = SEND_HI;
         else if (in_en_l) state_d = SEND_LO;
         else              state_d = IDLE;
      end else if (xfer) begin
         state_d = (state_q == SEND_HI && en_l_q) ? SEND_LO : IDLE;
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q <= IDLE;
         word_q  <= '0;
         en_l_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            word_q <= in_data;
            en_l_q <= in_en_l;
         end
         if (xfer) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

`ifdef HALFWORD_UNPACKER_PARITY_EN
   logic par_hi_q, par_lo_q;

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         par_hi_q <= 1'b0;
         par_lo_q <= 1'b0;
      end else if (accept) begin
         par_hi_q <= ^in_data[N-1:H];
         par_lo_q <= ^in_data[H-1:0];
      end
   end

   assign out_par = (state_q == SEND_HI) ? par_hi_q :
                    (state_q == SEND_LO) ? par_lo_q : 1'b0;
`endif

endmodule

// File: tb/tb_halfword_unpacker.sv
// Bench for halfword_unpacker: directed scenarios plus a randomized run against a queue-based model.
module tb_halfword_unpacker;
   localparam int N  = 16;
   localparam int H  = 8;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          clear = 1'b1;
   logic [N-1:0]  in_data = '0;
   logic          in_en_h = 1'b0, in_en_l = 1'b0, in_valid = 1'b0;
   logic          in_ready;
   logic [H-1:0]  out_data;
   logic          out_is_hi, out_last, out_valid;
   logic          out_ready = 1'b0;
   logic [CW-1:0] sent_cnt;
`ifdef HALFWORD_UNPACKER_PARITY_EN
   logic          out_par;
`endif

   int vec  = 0;
   int miss = 0;
   int unsigned exp_cnt = 0;

   always #5 clk = ~clk;

   halfword_unpacker #(.N(N), .CNT_W(CW)) dut (
      .clk(clk), .clear(clear),
      .in_data(in_data), .in_en_h(in_en_h), .in_en_l(in_en_l),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_is_hi(out_is_hi), .out_last(out_last),
      .out_valid(out_valid),
`ifdef HALFWORD_UNPACKER_PARITY_EN
      .out_par(out_par),
`endif
      .out_ready(out_ready), .sent_cnt(sent_cnt)
   );

   task automatic drive(input logic v, input logic [N-1:0] d, input logic eh, input logic el,
                        input logic r);
      in_valid = v; in_data = d; in_en_h = eh; in_en_l = el; out_ready = r;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      drive(0, '0, 0, 0, 0);
      clear = 1'b1;
      @(negedge clk);
      vec++; if ({out_valid, out_data, sent_cnt} !== '0) begin
         miss++; $display("FAIL reset_hold got v=%b d=%h cnt=%0d exp all 0", out_valid, out_data, sent_cnt);
      end
      next_cycle();
      clear = 1'b0;
      exp_cnt = 0;
      @(negedge clk);
      vec++; if ({in_ready, out_valid, out_data, sent_cnt} !== {1'b1, 1'b0, 8'h00, 8'h00}) begin
         miss++; $display("FAIL reset_release got rdy=%b v=%b d=%h cnt=%0d exp rdy=1 v=0 d=00 cnt=0",
                          in_ready, out_valid, out_data, sent_cnt);
      end
      next_cycle();
   endtask

   task automatic test_basic();
      drive(1, 16'hA55A, 1, 1, 1);
      @(negedge clk);
      vec++; if (in_ready !== 1'b1) begin miss++; $display("FAIL basic_accept_rdy got %b exp 1", in_ready); end
      next_cycle();
      drive(0, '0, 0, 0, 1);
      @(negedge clk);
      vec++; if ({out_valid, out_is_hi, out_last, out_data, in_ready} !== {3'b110, 8'hA5, 1'b0}) begin
         miss++; $display("FAIL basic_hi got v=%b hi=%b last=%b d=%h rdy=%b exp 1 1 0 a5 0",
                          out_valid, out_is_hi, out_last, out_data, in_ready);
      end
`ifdef HALFWORD_UNPACKER_PARITY_EN
      vec++; if (out_par !== 1'b0) begin miss++; $display("FAIL par_a5 got %b exp 0", out_par); end
`endif
      next_cycle();
      @(negedge clk);
      vec++; if ({out_valid, out_is_hi, out_last, out_data, in_ready} !== {3'b101, 8'h5A, 1'b1}) begin
         miss++; $display("FAIL basic_lo got v=%b hi=%b last=%b d=%h rdy=%b exp 1 0 1 5a 1",
                          out_valid, out_is_hi, out_last, out_data, in_ready);
      end
      next_cycle();
      exp_cnt += 2;
      @(negedge clk);
      vec++; if ({out_valid, sent_cnt} !== {1'b0, exp_cnt[CW-1:0]}) begin
         miss++; $display("FAIL basic_done got v=%b cnt=%0d exp v=0 cnt=%0d", out_valid, sent_cnt, exp_cnt[CW-1:0]);
      end
      next_cycle();
   endtask

   task automatic test_enables();
      drive(1, 16'h1234, 0, 1, 1);
      next_cycle();
      drive(1, 16'h5678, 0, 0, 1);
      @(negedge clk);
      vec++; if ({out_valid, out_is_hi, out_last, out_data, in_ready} !== {3'b101, 8'h34, 1'b1}) begin
         miss++; $display("FAIL en_lo_only got v=%b hi=%b last=%b d=%h rdy=%b exp 1 0 1 34 1",
                          out_valid, out_is_hi, out_last, out_data, in_ready);
      end
      next_cycle();
      drive(1, 16'h9ABC, 1, 0, 1);
      @(negedge clk);
      vec++; if ({out_valid, out_data, in_ready} !== {1'b0, 8'h00, 1'b1}) begin
         miss++; $display("FAIL en_none_dropped got v=%b d=%h rdy=%b exp 0 00 1", out_valid, out_data, in_ready);
      end
      next_cycle();
      drive(0, '0, 0, 0, 1);
      @(negedge clk);
      vec++; if ({out_valid, out_is_hi, out_last, out_data} !== {3'b111, 8'h9A}) begin
         miss++; $display("FAIL en_hi_only got v=%b hi=%b last=%b d=%h exp 1 1 1 9a",
                          out_valid, out_is_hi, out_last, out_data);
      end
      next_cycle();
      exp_cnt += 2;
      @(negedge clk);
      vec++; if ({out_valid, sent_cnt} !== {1'b0, exp_cnt[CW-1:0]}) begin
         miss++; $display("FAIL en_count got v=%b cnt=%0d exp v=0 cnt=%0d", out_valid, sent_cnt, exp_cnt[CW-1:0]);
      end
      next_cycle();
   endtask

   task automatic test_back_to_back();
      logic [H-1:0] exp_d [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
      logic         exp_r [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      drive(1, 16'h0102, 1, 1, 1);
      next_cycle();
      drive(1, 16'h0304, 1, 1, 1);
      for (int i = 0; i < 4; i++) begin
         if (i == 2) drive(0, '0, 0, 0, 1);
         @(negedge clk);
         vec++; if ({out_valid, out_is_hi, out_last, out_data, in_ready} !==
                    {1'b1, (i % 2 == 0), (i % 2 == 1), exp_d[i], exp_r[i]}) begin
            miss++; $display("FAIL b2b_%0d got v=%b hi=%b last=%b d=%h rdy=%b exp d=%h rdy=%b",
                             i, out_valid, out_is_hi, out_last, out_data, in_ready, exp_d[i], exp_r[i]);
         end
         next_cycle();
      end
      exp_cnt += 4;
      @(negedge clk);
      vec++; if ({out_valid, sent_cnt} !== {1'b0, exp_cnt[CW-1:0]}) begin
         miss++; $display("FAIL b2b_end got v=%b cnt=%0d exp v=0 cnt=%0d", out_valid, sent_cnt, exp_cnt[CW-1:0]);
      end
      next_cycle();
   endtask

   task automatic test_stall_clear();
      drive(1, 16'hBEEF, 1, 1, 0);
      next_cycle();
      drive(1, 16'h1111, 0, 1, 0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         vec++; if ({out_valid, out_is_hi, out_data, in_ready} !== {2'b11, 8'hBE, 1'b0}) begin
            miss++; $display("FAIL stall_hold_%0d got v=%b hi=%b d=%h rdy=%b exp 1 1 be 0",
                             i, out_valid, out_is_hi, out_data, in_ready);
         end
         next_cycle();
      end
      clear = 1'b1;
      #1;
      exp_cnt = 0;
      vec++; if ({out_valid, out_data, sent_cnt} !== '0) begin
         miss++; $display("FAIL clear_midword got v=%b d=%h cnt=%0d exp 0 00 0", out_valid, out_data, sent_cnt);
      end
      next_cycle();
      clear = 1'b0;
      drive(0, '0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vec++; if ({out_valid, in_ready, sent_cnt} !== {1'b0, 1'b1, 8'h00}) begin
            miss++; $display("FAIL clear_abandon_%0d got v=%b d=%h rdy=%b cnt=%0d exp v=0 rdy=1 cnt=0",
                             i, out_valid, out_data, in_ready, sent_cnt);
         end
         next_cycle();
      end
   endtask

   task automatic test_wrap();
      // 128 two-half words streamed back to back: 256 transfers, counter returns to 0.
      for (int c = 0; c <= 256; c++) begin
         drive(c <= 254, 16'(c * 16'h0101), 1, 1, 1);
         if (c == 256) begin
            @(negedge clk);
            vec++; if (sent_cnt !== 8'd255) begin
               miss++; $display("FAIL wrap_255 got %0d exp 255", sent_cnt);
            end
         end
         next_cycle();
      end
      exp_cnt += 256;
      @(negedge clk);
      vec++; if ({out_valid, sent_cnt} !== {1'b0, exp_cnt[CW-1:0]}) begin
         miss++; $display("FAIL wrap_zero got v=%b cnt=%0d exp v=0 cnt=%0d", out_valid, sent_cnt, exp_cnt[CW-1:0]);
      end
      next_cycle();
   endtask

`ifdef HALFWORD_UNPACKER_PARITY_EN
   task automatic test_parity();
      drive(1, 16'h0700, 1, 0, 0);
      next_cycle();
      drive(0, '0, 0, 0, 1);
      @(negedge clk);
      vec++; if ({out_data, out_par} !== {8'h07, 1'b1}) begin
         miss++; $display("FAIL par_07 got d=%h par=%b exp 07 1", out_data, out_par);
      end
      next_cycle();
      exp_cnt += 1;
      @(negedge clk);
      vec++; if (out_par !== 1'b0) begin miss++; $display("FAIL par_idle got %b exp 0", out_par); end
      next_cycle();
   endtask
`endif

   task automatic test_random();
      // Model: queue of halves still owed for the current word, each {is_hi, last, data}.
      logic [H+1:0] q[$];
      logic         v, eh, el, r, exp_rdy;
      logic [N-1:0] d;
      for (int c = 0; c < 400; c++) begin
         v  = ($urandom_range(0, 3) != 0);
         eh = $urandom_range(0, 1) == 1;
         el = $urandom_range(0, 1) == 1;
         r  = ($urandom_range(0, 3) != 0);
         d  = 16'($urandom);
         drive(v, d, eh, el, r);
         @(negedge clk);
         exp_rdy = (q.size() == 0) || (r && q.size() == 1);
         if (q.size() != 0) begin
            vec++; if ({out_valid, out_is_hi, out_last, out_data} !== {1'b1, q[0]}) begin
               miss++; $display("FAIL rand_out c=%0d got v=%b hi=%b last=%b d=%h exp hi=%b last=%b d=%h",
                                c, out_valid, out_is_hi, out_last, out_data, q[0][H+1], q[0][H], q[0][H-1:0]);
            end
`ifdef HALFWORD_UNPACKER_PARITY_EN
            vec++; if (out_par !== ^q[0][H-1:0]) begin
               miss++; $display("FAIL rand_par c=%0d got %b exp %b", c, out_par, ^q[0][H-1:0]);
            end
`endif
         end else begin
            vec++; if ({out_valid, out_data} !== '0) begin
               miss++; $display("FAIL rand_idle c=%0d got v=%b d=%h exp 0 00", c, out_valid, out_data);
            end
         end
         vec++; if ({in_ready, sent_cnt} !== {exp_rdy, exp_cnt[CW-1:0]}) begin
            miss++; $display("FAIL rand_ctl c=%0d got rdy=%b cnt=%0d exp rdy=%b cnt=%0d",
                             c, in_ready, sent_cnt, exp_rdy, exp_cnt[CW-1:0]);
         end
         if (q.size() != 0 && r) begin
            void'(q.pop_front());
            exp_cnt++;
         end
         if (v && exp_rdy) begin
            if (eh) q.push_back({1'b1, !el, d[N-1:H]});
            if (el) q.push_back({1'b0, 1'b1, d[H-1:0]});
         end
         next_cycle();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_enables();
      test_back_to_back();
      test_stall_clear();
      test_wrap();
`ifdef HALFWORD_UNPACKER_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule

// File: doc/halfword_unpacker.md
Name: halfword_unpacker

Overview:
- Read side of the half-addressable register path. The register block assembles a word from separately loaded high and low halves; this block does the reverse.
- It takes one N-bit word per input handshake and emits its halves on an N/2-bit bus, high half first.
- Two per-word enables select which halves are sent.
- It sits between a word-wide producer (register or datapath) and a half-width consumer (byte bus, display or UART front end).

Parameters:
- N, 16, full word width; must be even and at least 4.
- CNT_W, 8, width of the sent-halves counter.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- clear  input  1  asynchronous active-high reset.
- in_data  input  N  word to unpack.
- in_en_h  input  1  send high half of this word.
- in_en_l  input  1  send low half of this word.
- in_valid  input  1  producer offers in_data, in_en_h and in_en_l.
- in_ready  output  1  block accepts a word this cycle.
- out_data  output  N/2  current half.
- out_is_hi  output  1  1 means out_data is the high half (in_data[N-1:N/2]); 0 means the low half (in_data[N/2-1:0]).
- out_last  output  1  current half is the final half of its word.
- out_valid  output  1  out_data, out_is_hi and out_last are valid.
- out_ready  input  1  consumer takes the half.
- sent_cnt  output  CNT_W  count of completed output handshakes.

Behaviour:
- Reset: clear asserted, asynchronous, active-high.
  - state becomes IDLE; word, en_h and en_l registers go to 0; sent_cnt goes to 0.
  - out_valid, out_data, out_is_hi and out_last read 0; in_ready reads 1 once clear deasserts.
  - Asserting clear mid-word abandons the word: out_valid falls immediately and no further half of that word is emitted.
- States: IDLE, SEND_HI, SEND_LO.
- Accept: when in_valid and in_ready are high at a rising edge, capture in_data, in_en_h and in_en_l. Next state:
  - in_en_h=1: SEND_HI.
  - in_en_h=0, in_en_l=1: SEND_LO.
  - both 0: IDLE. The word is consumed and dropped; nothing is emitted and sent_cnt does not change.
- Output decode: all outputs decode from registered state only, with no combinational path from in_* to out_*.
  - IDLE: out_valid=0, out_data=0.
  - SEND_HI: out_valid=1, out_data=word[N-1:N/2], out_is_hi=1, out_last=!en_l.
  - SEND_LO: out_valid=1, out_data=word[N/2-1:0], out_is_hi=0, out_last=1.
- Output handshake: a transfer occurs when out_valid and out_ready are high at a rising edge.
  - out_data, out_is_hi and out_last hold stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer, except on clear.
- Transitions on a transfer:
  - SEND_HI with en_l=1: go to SEND_LO.
  - SEND_HI with en_l=0: word done.
  - SEND_LO: word done.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last).
  - This is a combinational path from out_ready to in_ready. It is intended and gives zero-bubble back-to-back words.
- Word done with a simultaneous accept: load the new word and enter its first state directly, with no IDLE cycle.
- Word done without an accept: go to IDLE.
- Throughput: one half per cycle when out_ready is held at 1. Two halves per word gives one word every 2 cycles.
- Latency: the first half of an accepted word is valid in the cycle after acceptance.
- sent_cnt: increments by 1 on every output transfer and wraps from 2^CNT_W-1 to 0.
- in_* inputs are ignored whenever in_ready=0.

Optional Feature:
- Macro HALFWORD_UNPACKER_PARITY_EN.
- Defined:
  - Adds output out_par (1 bit) = even parity of out_data, so that XOR over out_data and out_par is 0.
  - out_par is registered alongside the captured word.
  - It reads 0 on reset and in IDLE, and follows the same stability rules as out_data.
- Undefined: the out_par port does not exist; everything else is identical.

Test Plan:
- Reset release with idle producer -> in_ready=1, out_valid=0, out_data=0, sent_cnt=0.
- Accept 16'hA55A with en_h=1, en_l=1, out_ready=1 -> next cycle out_data=8'hA5, out_is_hi=1, out_last=0; following cycle out_data=8'h5A, out_is_hi=0, out_last=1; sent_cnt=2.
- Words 16'h1234 (en_h=0, en_l=1), then 16'h5678 (both enables 0), then 16'h9ABC (en_h=1, en_l=0) -> only 8'h34 (lo, last) and 8'h9A (hi, last) are emitted; sent_cnt=2.
- Back-to-back words 16'h0102 and 16'h0304 with in_valid and out_ready held at 1 -> gap-free stream 01,02,03,04; in_ready pulses 1 in the cycle 02 transfers.
- Word 16'hBEEF with out_ready=0 for 5 cycles -> out_data holds 8'hBE and in_ready stays 0; assert clear in cycle 3 -> out_valid drops at once and 8'hEF is never emitted.
- Issue 256 half transfers with CNT_W=8 -> sent_cnt wraps to 0; with HALFWORD_UNPACKER_PARITY_EN defined, 8'hA5 gives out_par=0 and 8'h07 gives out_par=1.
